bl_scan_ctrl: RTL and testbench



---
 rtl/bl_scan_ctrl_if.sv | 27 ++
 rtl/bl_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_bl_scan_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bl_scan_ctrl_if.sv
// Bitline scan sequencer bus: request/abort inputs and
// the enable/address/status outputs to the mux stage.
interface bl_scan_ctrl_if;
    logic       Start;
    logic       Abort;
    logic       Single;
    logic [2:0] Addr_in;
    logic       EN_out;
    logic       A2_out;
    logic       A1_out;
    logic       A0_out;
    logic       Busy;
    logic       Done;
    logic       Aborted;

    modport master (
        output Start, Abort, Single, Addr_in,
        input  EN_out, A2_out, A1_out, A0_out,
        input  Busy, Done, Aborted
    );

    modport slave (
        input  Start, Abort, Single, Addr_in,
        output EN_out, A2_out, A1_out, A0_out,
        output Busy, Done, Aborted
    );
endinterface

// File: rtl/bl_scan_ctrl.sv
// Bitline scan sequencer: setup/dwell/hold/gap per address.
// Optional BL_SCAN_LOOP_EN makes full scans repeat until Abort.
module bl_scan_ctrl #(
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 7,
    parameter int DWELL      = 4,
    parameter int GAP        = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    bl_scan_ctrl_if.slave bus
);

    localparam logic [2:0] FIRST_A  = 3'(FIRST_ADDR);
    localparam logic [2:0] LAST_A   = 3'(LAST_ADDR);
    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam bit         HAS_GAP  = (GAP > 0);
    localparam logic [7:0] GAP_M1   = HAS_GAP ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_DWELL, S_HOLD,
        S_GAP, S_DONE, S_ABORT
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] addr_q, addr_d, nxt_addr;
    logic [7:0] cnt_q, cnt_d;
    logic       single_q, single_d;
    logic       finish, pass_done, working;

    logic       en_q, en_d;
    logic [2:0] a_q, a_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       aborted_q, aborted_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        single_d = single_q;
`ifdef BL_SCAN_LOOP_EN
        nxt_addr  = (addr_q == LAST_A) ? FIRST_A
                                       : addr_q + 3'd1;
        finish    = single_q;
        pass_done = (addr_q == LAST_A) && !single_q;
`else
        nxt_addr  = addr_q + 3'd1;
        finish    = single_q || (addr_q == LAST_A);
        pass_done = 1'b0;
`endif
        working = state_q inside {S_SETUP, S_DWELL,
                                  S_HOLD, S_GAP};

        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d  = S_SETUP;
                    single_d = bus.Single;
                    addr_d   = bus.Single ? bus.Addr_in
                                          : FIRST_A;
                end
            end
            S_SETUP: begin
                state_d = S_DWELL;
                cnt_d   = DWELL_M1;
            end
            S_DWELL: begin
                if (cnt_q == 8'd0) state_d = S_HOLD;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_HOLD: begin
                if (finish) begin
                    state_d = S_DONE;
                end else if (HAS_GAP) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_M1;
                end else begin
                    state_d = S_SETUP;
                    addr_d  = nxt_addr;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SETUP;
                    addr_d  = nxt_addr;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
                addr_d  = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = 3'd0;
            end
        endcase

        // Abort beats every other transition out of an active state
        if (bus.Abort && working) begin
            state_d = S_ABORT;
            addr_d  = addr_q;
            cnt_d   = cnt_q;
        end

        en_d      = (state_d == S_DWELL);
        a_d       = (state_d == S_IDLE) ? 3'd0 : addr_d;
        busy_d    = (state_d != S_IDLE);
        aborted_d = (state_d == S_ABORT);
        done_d    = (state_d == S_DONE) ||
                    (state_q == S_HOLD && state_d != S_ABORT &&
                     pass_done);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 3'd0;
            cnt_q     <= 8'd0;
            single_q  <= 1'b0;
            en_q      <= 1'b0;
            a_q       <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            single_q  <= single_d;
            en_q      <= en_d;
            a_q       <= a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.EN_out  = en_q;
    assign bus.A2_out  = a_q[2];
    assign bus.A1_out  = a_q[1];
    assign bus.A0_out  = a_q[0];
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Aborted = aborted_q;

endmodule

// File: tb/tb_bl_scan_ctrl.sv
// Bench for bl_scan_ctrl: per-cycle traces from a scan-list model,
// default config plus FIRST=6/LAST=7/DWELL=1/GAP=0.
module tb_bl_scan_ctrl;

    typedef struct packed {
        logic       abl;
        logic [6:0] v;
    } exp_t;

    logic Clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   failures = 0;
    int   en_seen;

    bl_scan_ctrl_if b0 ();
    bl_scan_ctrl_if b1 ();

    bl_scan_ctrl u0 (
        .Clk   (Clk),
        .Reset (rst0),
        .bus   (b0)
    );

    bl_scan_ctrl #(
        .FIRST_ADDR (6),
        .LAST_ADDR  (7),
        .DWELL      (1),
        .GAP        (0)
    ) u1 (
        .Clk   (Clk),
        .Reset (rst1),
        .bus   (b1)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] obs(input bit cfg);
        if (cfg)
            return {b1.EN_out, b1.A2_out, b1.A1_out, b1.A0_out,
                    b1.Busy, b1.Done, b1.Aborted};
        return {b0.EN_out, b0.A2_out, b0.A1_out, b0.A0_out,
                b0.Busy, b0.Done, b0.Aborted};
    endfunction

    function automatic exp_t mk(input bit abl, input bit en,
                                input int a, input bit bz,
                                input bit dn, input bit ab);
        exp_t e;
        e.abl = abl;
        e.v   = {en, 3'(a), bz, dn, ab};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [6:0] o,
                       input logic [6:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic drv(input bit cfg, input logic st,
                       input logic ab, input logic sg,
                       input logic [2:0] ad);
        if (cfg) begin
            b1.Start = st; b1.Abort = ab;
            b1.Single = sg; b1.Addr_in = ad;
        end else begin
            b0.Start = st; b0.Abort = ab;
            b0.Single = sg; b0.Addr_in = ad;
        end
    endtask

    // Expected trace, index 0 = first cycle after the Start edge
    task automatic model(input bit cfg, input bit single,
                         input logic [2:0] sa, input int abort_at,
                         input int reset_at, output exp_t q[$]);
        int first, last, dw, gp, passes, a;
        int addrs[$];
        bit loop, pend;
        exp_t e;
        first = cfg ? 6 : 0;
        last  = 7;
        dw    = cfg ? 1 : 4;
        gp    = cfg ? 0 : 1;
        loop  = 1'b0;
`ifdef BL_SCAN_LOOP_EN
        loop = !single;
`endif
        q = {};
        pend = 1'b0;
        passes = loop ? 12 : 1;
        if (single) addrs.push_back(int'(sa));
        else
            for (int p = 0; p < passes; p++)
                for (int x = first; x <= last; x++)
                    addrs.push_back(x);
        for (int k = 0; k < addrs.size(); k++) begin
            a = addrs[k];
            e = mk(1, 0, a, 1, 0, 0);
            if (pend) begin e.v[1] = 1'b1; pend = 1'b0; end
            q.push_back(e);
            for (int d = 0; d < dw; d++)
                q.push_back(mk(1, 1, a, 1, 0, 0));
            q.push_back(mk(1, 0, a, 1, 0, 0));
            if (loop && a == last) pend = 1'b1;
            if (k != addrs.size() - 1)
                for (int g = 0; g < gp; g++) begin
                    e = mk(1, 0, a, 1, 0, 0);
                    if (pend) begin e.v[1] = 1'b1; pend = 1'b0; end
                    q.push_back(e);
                end
        end
        if (!loop) begin
            q.push_back(mk(0, 0, addrs[addrs.size()-1], 1, 1, 0));
            q.push_back(mk(0, 0, 0, 0, 0, 0));
        end
        if (abort_at >= 0 && abort_at < q.size() &&
            q[abort_at].abl) begin
            a = int'(q[abort_at].v[5:3]);
            while (q.size() > abort_at + 1) void'(q.pop_back());
            q.push_back(mk(0, 0, a, 1, 0, 1));
            q.push_back(mk(0, 0, 0, 0, 0, 0));
        end
        if (reset_at >= 0 && reset_at < q.size()) begin
            while (q.size() > reset_at + 1) void'(q.pop_back());
            q.push_back(mk(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic run(input bit cfg, input bit single,
                       input logic [2:0] sa, input int abort_at,
                       input int reset_at, input bit noise,
                       input bit ab_with_start, input string tag);
        exp_t q[$];
        logic n_st, n_sg;
        logic [2:0] n_ad;
        int ab_i;
        ab_i = abort_at;
`ifdef BL_SCAN_LOOP_EN
        if (!single && ab_i < 0 && reset_at < 0) ab_i = 20;
`endif
        model(cfg, single, sa, ab_i, reset_at, q);
        en_seen = 0;
        @(negedge Clk);
        drv(cfg, 1'b1, ab_with_start, single, sa);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge Clk);
            chk($sformatf("%s[%0d]", tag, i), obs(cfg), q[i].v);
            if (obs(cfg) [6] === 1'b1) en_seen++;
            n_st = noise && q[i].v[2] && ($urandom_range(0, 1) == 1);
            n_sg = noise ? 1'($urandom_range(0, 1)) : single;
            n_ad = noise ? 3'($urandom_range(0, 7)) : sa;
            drv(cfg, n_st, (i == ab_i), n_sg, n_ad);
            if (cfg) rst1 = (i == reset_at);
            else     rst0 = (i == reset_at);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drv(0, 0, 0, 0, 3'd0);
        drv(1, 0, 0, 0, 3'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_u0", obs(0), 7'd0);
        chk("reset_u1", obs(1), 7'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        drv(0, 0, 1, 0, 3'd0);
        drv(1, 0, 1, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("idle_abort_u0", obs(0), 7'd0);
            chk("idle_abort_u1", obs(1), 7'd0);
        end
        drv(0, 0, 0, 0, 3'd0);
        drv(1, 0, 0, 0, 3'd0);

        run(0, 0, 3'd0, -1, -1, 1, 0, "full");
`ifndef BL_SCAN_LOOP_EN
        chk("full_en_cycles", 7'(en_seen), 7'd32);
`endif
        run(0, 1, 3'd5, -1, -1, 0, 0, "single5");
        run(0, 0, 3'd0, 17, -1, 0, 0, "abort_a2");
        run(0, 0, 3'd0, -1, 30, 0, 0, "reset_a4");
        run(0, 0, 3'd0, -1, -1, 0, 0, "restart");
        run(0, 0, 3'd0, 55, -1, 0, 0, "abort_in_done");
        run(0, 0, 3'd0, -1, -1, 0, 1, "start_abort_idle");
        run(0, 0, 3'd0, 0, -1, 0, 1, "abort_held");
        run(1, 0, 3'd0, -1, -1, 1, 0, "short_full");
        run(1, 1, 3'd3, -1, -1, 1, 0, "short_single");
        run(1, 0, 3'd0, 4, -1, 0, 0, "short_abort");

        for (int r = 0; r < 20; r++) begin
            bit cf, sg, nz;
            int ab;
            cf = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            nz = 1'($urandom_range(0, 1));
            ab = ($urandom_range(0, 2) == 0) ? -1
                 : int'($urandom_range(0, 60));
            run(cf, sg, 3'($urandom_range(0, 7)), ab, -1, nz, 0,
                $sformatf("rand%0d", r));
        end

        @(negedge Clk);
        chk("final_idle_u0", obs(0), 7'd0);
        chk("final_idle_u1", obs(1), 7'd0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
